// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: word/address sizes, their types, and the
// helper that extracts one word from a packed memory image.
//   init_word(image, i) : word i of a MEM_DEPTH*WORD_W image; address 0 is
//                         the most-significant chunk of the image.
package cpu_pkg;

   localparam int unsigned WORD_W    = 20;
   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   function automatic word_t init_word(input logic [MEM_DEPTH*WORD_W-1:0] image,
                                       input int unsigned i);
      return image[(MEM_DEPTH-1-i)*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/memory_unit.sv
// Unified instruction/data memory for the CPU datapath.
// One synchronous write port and two independent combinational read ports.
//   clk       : write clock (rising edge)
//   rst       : async active-high; reloads every word from INSTRUCTIONS
//   addr      : data read/write address
//   PC        : instruction fetch address
//   write     : write data
//   wr_select : write enable, sampled on the rising edge of clk
//   read      : mem[addr], combinational
//   inst      : mem[PC], combinational
module memory_unit #(
   parameter int unsigned WORD_W = cpu_pkg::WORD_W,
   parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
   parameter logic [(2**ADDR_W)*WORD_W-1:0] INSTRUCTIONS = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] PC,
   input  logic [WORD_W-1:0] write,
   input  logic              wr_select,
   output logic [WORD_W-1:0] read,
   output logic [WORD_W-1:0] inst
);

   import cpu_pkg::*;

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [WORD_W-1:0] mem_q [Depth];
   logic [WORD_W-1:0] mem_d [Depth];

   always_comb begin
      mem_d = mem_q;
      if (wr_select) begin
         mem_d[addr] = write;
      end
   end

   // Reset has priority, so a write pending in the same cycle is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= init_word(INSTRUCTIONS, i);
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // No write-data bypass: a pending write only shows after its clock edge.
   assign read = mem_q[addr];
   assign inst = mem_q[PC];

endmodule

// File: tb/tb_memory_unit.sv
module tb_memory_unit;

   import cpu_pkg::*;

   localparam logic [MEM_DEPTH*WORD_W-1:0] Image =
      {20'h01234, 20'h56789, 20'hABCDE, 20'hF06CC, {((MEM_DEPTH-4)*WORD_W){1'b0}}};

   logic  clk = 1'b0;
   logic  rst;
   addr_t addr;
   addr_t pc;
   word_t wdata;
   logic  wr_select;
   word_t read;
   word_t inst;

   memory_unit #(
      .WORD_W      (WORD_W),
      .ADDR_W      (ADDR_W),
      .INSTRUCTIONS(Image)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .PC       (pc),
      .write    (wdata),
      .wr_select(wr_select),
      .read     (read),
      .inst     (inst)
   );

   always #5 clk = ~clk;

   word_t ref_mem [MEM_DEPTH];
   word_t exp_q [$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic ref_reset();
      for (int i = 0; i < int'(MEM_DEPTH); i++) ref_mem[i] = '0;
      ref_mem[0] = 20'h01234;
      ref_mem[1] = 20'h56789;
      ref_mem[2] = 20'hABCDE;
      ref_mem[3] = 20'hF06CC;
   endtask

   // Pops the next expected value from the scoreboard and compares.
   task automatic cmp(input string tag, input word_t obs);
      word_t exp;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %05h expected <scoreboard empty>", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
         end
      end
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; addr = '0; pc = '0; wdata = '0; wr_select = 1'b0;
      ref_reset();
      #2 rst = 1'b1;
      #10 rst = 1'b0;
      #1;

      // Reset image
      exp_q.push_back(20'h01234); cmp("img_read_a0", read);
      exp_q.push_back(20'h01234); cmp("img_inst_pc0", inst);
      pc = 10'd3; #1;
      exp_q.push_back(20'hF06CC); cmp("img_inst_pc3", inst);
      addr = 10'd1023; #1;
      exp_q.push_back(20'h00000); cmp("img_read_a1023", read);

      // Write visible only after the edge, on both ports when PC == addr
      @(negedge clk);
      addr = 10'd1; pc = 10'd1; wdata = 20'h004D2; wr_select = 1'b1; #1;
      exp_q.push_back(20'h56789); cmp("pre_edge_read", read);
      exp_q.push_back(20'h56789); cmp("pre_edge_inst", inst);
      after_edge();
      exp_q.push_back(20'h004D2); cmp("post_edge_read", read);
      exp_q.push_back(20'h004D2); cmp("post_edge_inst", inst);
      wr_select = 1'b0;

      // Single write, then disabled writes leave memory untouched
      @(negedge clk);
      addr = 10'd2; wdata = 20'h02694; wr_select = 1'b1;
      after_edge();
      wr_select = 1'b0; #1;
      exp_q.push_back(20'h02694); cmp("wr_a2", read);
      addr = 10'd3; wdata = 20'h02710;
      repeat (3) after_edge();
      exp_q.push_back(20'hF06CC); cmp("no_wr_a3", read);

      // Write elsewhere does not disturb the fetch port
      @(negedge clk);
      addr = 10'd4; pc = 10'd0; wdata = 20'h00005; wr_select = 1'b1;
      after_edge();
      exp_q.push_back(20'h00005); cmp("wr_a4", read);
      exp_q.push_back(20'h01234); cmp("inst_undisturbed", inst);
      wr_select = 1'b0;
      addr = 10'd5; #1;
      exp_q.push_back(20'h00000); cmp("read_a5", read);

      // Asynchronous reset mid-cycle with writes enabled
      @(negedge clk);
      addr = 10'd1; wdata = 20'hFFFFF; wr_select = 1'b1;
      #2 rst = 1'b1;
      #1;
      exp_q.push_back(20'h56789); cmp("rst_read_a1", read);
      addr = 10'd2; #1;
      exp_q.push_back(20'hABCDE); cmp("rst_read_a2", read);
      addr = 10'd4; #1;
      exp_q.push_back(20'h00000); cmp("rst_read_a4", read);
      after_edge();
      exp_q.push_back(20'h00000); cmp("rst_blocks_write", read);
      #2 rst = 1'b0;
      wdata = 20'h0AAAA; #1;
      exp_q.push_back(20'h00000); cmp("post_rst_pre_edge", read);
      after_edge();
      exp_q.push_back(20'h0AAAA); cmp("post_rst_write", read);
      wr_select = 1'b0;
      ref_reset();
      ref_mem[4] = 20'h0AAAA;

      // Random traffic against the reference model
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         case ($urandom_range(0, 3))
            0:       addr = '0;
            1:       addr = 10'd1023;
            default: addr = addr_t'($urandom_range(0, 1023));
         endcase
         if ($urandom_range(0, 3) == 0) pc = addr;
         else if ($urandom_range(0, 7) == 0) pc = 10'd1023;
         else pc = addr_t'($urandom_range(0, 1023));
         wdata     = word_t'($urandom_range(0, 20'hFFFFF));
         wr_select = 1'($urandom_range(0, 1));
         #1;
         exp_q.push_back(ref_mem[addr]); cmp("rand_pre_read", read);
         exp_q.push_back(ref_mem[pc]);   cmp("rand_pre_inst", inst);
         @(posedge clk);
         if (wr_select) ref_mem[addr] = wdata;
         #1;
         exp_q.push_back(ref_mem[addr]); cmp("rand_post_read", read);
         exp_q.push_back(ref_mem[pc]);   cmp("rand_post_inst", inst);
      end
      wr_select = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
